a2s_arbiter: RTL

Round-robin arbiter and response side of the slave-to-arbiter request/acknowledge interface. It sits downstream of NUM_CH slave channel buffers and samples each buffer's valid/data pair. It returns a one-hot acknowledge to the granted buffer, then forwards the accepted word with its channel id through a 2-entry output buffer to the formatter stage, using a valid/ready handshake.

---
 rtl/a2s_pkg.sv | 43 ++++
 rtl/a2s_obuf.sv | 56 +++++
 rtl/a2s_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/a2s_pkg.sv
// ---------------------------------------------------------------------------
// a2s_pkg
// Shared definitions for the slave-to-arbiter response path.
//   A2S_NUM_CH / A2S_DW / A2S_BURST_LEN : default configuration
//   a2s_entry_t                         : {id, data} word held in the output buffer
//   rr_pick(req, ptr)                   : one-hot round-robin pick starting at ptr
// ---------------------------------------------------------------------------
package a2s_pkg;

   localparam int A2S_NUM_CH    = 3;
   localparam int A2S_DW        = 32;
   localparam int A2S_BURST_LEN = 4;
   localparam int A2S_IDW       = $clog2(A2S_NUM_CH);

   // Widest supported channel count; rr_pick works on vectors of this width.
   localparam int A2S_MAX_CH    = 8;

   typedef struct packed {
      logic [A2S_IDW-1:0] id;
      logic [A2S_DW-1:0]  data;
   } a2s_entry_t;

   // Searches ptr, ptr+1, ... modulo 8. Callers zero-extend a NUM_CH-wide
   // request, so the empty top bits are skipped and the visiting order equals
   // a search modulo NUM_CH.
   function automatic logic [A2S_MAX_CH-1:0] rr_pick(input logic [A2S_MAX_CH-1:0] req,
                                                     input logic [2:0]            ptr);
      logic [A2S_MAX_CH-1:0] grant;
      logic [2:0]            idx;
      logic                  found;
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < A2S_MAX_CH; i++) begin
         idx = ptr + 3'(i);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/a2s_obuf.sv
// ---------------------------------------------------------------------------
// a2s_obuf
// Two-entry FIFO holding accepted {id, data} words until the formatter takes
// them.
//   clk, rstn : clock, synchronous active-low reset
//   push, din : write one entry (caller guarantees count < 2)
//   pop       : drop the head entry (caller guarantees count > 0)
//   head      : oldest entry, stable until popped
//   count     : occupancy 0..2
// ---------------------------------------------------------------------------
module a2s_obuf
   import a2s_pkg::*;
#(
   parameter type entry_t = a2s_entry_t
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       push,
   input  entry_t     din,
   input  logic       pop,
   output entry_t     head,
   output logic [1:0] count
);

   entry_t mem [2];
   logic   wr_ptr;
   logic   rd_ptr;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         // NOTE: the storage is reset too, because the head drives the output
         // word directly and must read as zero straight out of reset.
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/a2s_arbiter.sv
// ---------------------------------------------------------------------------
// a2s_arbiter
// Round-robin arbiter over NUM_CH slave channel buffers. Acknowledges one
// eligible channel per cycle, captures its word with the channel id into a
// 2-entry output buffer and presents it downstream with valid/ready.
//   clk_i, rstn_i : clock, synchronous active-low reset
//   slv_val_i     : per-channel word valid
//   slv_dat_i     : per-channel data, channel k at [k*DW +: DW]
//   slv_en_i      : per-channel arbitration enable
//   a2s_ack_o     : one-hot acknowledge; a word moves when val & ack
//   arb_val_o     : output word valid
//   arb_dat_o     : output word
//   arb_id_o      : source channel of arb_dat_o
//   arb_rdy_i     : downstream ready
//   arb_cnt_o     : output buffer occupancy
// Build option A2S_ARBITER_BURST_EN: a granted channel keeps priority for up
// to BURST_LEN consecutive words while it stays eligible.
// ---------------------------------------------------------------------------
module a2s_arbiter
   import a2s_pkg::*;
#(
   parameter int NUM_CH    = A2S_NUM_CH,
   parameter int DW        = A2S_DW,
   parameter int BURST_LEN = A2S_BURST_LEN
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic [NUM_CH-1:0]          slv_val_i,
   input  logic [NUM_CH*DW-1:0]       slv_dat_i,
   input  logic [NUM_CH-1:0]          slv_en_i,
   output logic [NUM_CH-1:0]          a2s_ack_o,
   output logic                       arb_val_o,
   output logic [DW-1:0]              arb_dat_o,
   output logic [$clog2(NUM_CH)-1:0]  arb_id_o,
   input  logic                       arb_rdy_i,
   output logic [1:0]                 arb_cnt_o
);

   localparam int IDW = $clog2(NUM_CH);

   if (NUM_CH < 2 || NUM_CH > A2S_MAX_CH || BURST_LEN < 1) begin : g_cfg_check
      $error("a2s_arbiter: unsupported NUM_CH or BURST_LEN");
   end

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [DW-1:0]  data;
   } entry_t;

   logic [NUM_CH-1:0] eligible;
   logic [NUM_CH-1:0] ack;
   logic [IDW-1:0]    rr_ptr;
   logic [IDW-1:0]    rr_ptr_nxt;
   logic [IDW-1:0]    gnt_id;
   logic              grant;
   logic              pop;
   logic [1:0]        count;
   entry_t            push_entry;
   entry_t            head;

   function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] ch);
      return (ch == IDW'(NUM_CH - 1)) ? '0 : ch + 1'b1;
   endfunction

   assign eligible = slv_val_i & slv_en_i;

   // Ack depends only on inputs from the slaves and registered state; the
   // registered count gates it, so a pop frees space only from the next cycle.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a value unassigned, which would otherwise infer a latch.
      ack        = '0;
      gnt_id     = '0;
      push_entry = '0;
      if (rstn_i && count != 2'd2) begin
         ack = NUM_CH'(rr_pick(A2S_MAX_CH'(eligible), 3'(rr_ptr)));
      end
      for (int k = 0; k < NUM_CH; k++) begin
         if (ack[k]) begin
            gnt_id          = IDW'(k);
            push_entry.data = slv_dat_i[k*DW +: DW];
         end
      end
      push_entry.id = gnt_id;
   end

   assign grant = |ack;
   assign pop   = arb_val_o && arb_rdy_i;

`ifdef A2S_ARBITER_BURST_EN
   localparam int BCW = $clog2(BURST_LEN + 1);

   logic [BCW-1:0] burst_cnt;
   logic [BCW-1:0] burst_cnt_nxt;
   logic [BCW-1:0] burst_run;

   // rr_ptr stays on the bursting channel so it wins the next search; a grant
   // elsewhere (pointer channel dropped out) starts a fresh burst.
   always_comb begin
      rr_ptr_nxt    = rr_ptr;
      burst_cnt_nxt = burst_cnt;
      burst_run     = '0;
      if (grant) begin
         burst_run = ((gnt_id == rr_ptr) ? burst_cnt : '0) + 1'b1;
         if (burst_run >= BCW'(BURST_LEN)) begin
            rr_ptr_nxt    = wrap_inc(gnt_id);
            burst_cnt_nxt = '0;
         end else begin
            rr_ptr_nxt    = gnt_id;
            burst_cnt_nxt = burst_run;
         end
      end else if (burst_cnt != '0 && !eligible[rr_ptr]) begin
         rr_ptr_nxt    = wrap_inc(rr_ptr);
         burst_cnt_nxt = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         burst_cnt <= '0;
      end else begin
         burst_cnt <= burst_cnt_nxt;
      end
   end
`else
   always_comb begin
      rr_ptr_nxt = rr_ptr;
      if (grant) begin
         rr_ptr_nxt = wrap_inc(gnt_id);
      end
   end
`endif

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         // NOTE: state registers use non-blocking assignments so every
         // always_ff samples the pre-edge values of the others.
         rr_ptr <= '0;
      end else begin
         rr_ptr <= rr_ptr_nxt;
      end
   end

   a2s_obuf #(
      .entry_t (entry_t)
   ) u_obuf (
      .clk   (clk_i),
      .rstn  (rstn_i),
      .push  (grant),
      .din   (push_entry),
      .pop   (pop),
      .head  (head),
      .count (count)
   );

   assign a2s_ack_o = ack;
   assign arb_val_o = (count != 2'd0);
   assign arb_dat_o = head.data;
   assign arb_id_o  = head.id;
   assign arb_cnt_o = count;

endmodule
